neuron_layer_seq: RTL and testbench
===================================

NEURON_LAYER_SEQ -- requirements
Module: neuron_layer_seq

Interface
REQ-001 SHALL have parameter IN_W, default 5, meaning bit width of each activation input.
REQ-002 SHALL have parameter OUT_W, default 12, meaning bit width of each neuron result.
REQ-003 SHALL have parameter NUM_NEURONS, default 8, range 2..64, meaning number of neurons in the layer that time-share one neuron unit.
REQ-004 SHALL have port clk, input, 1, the single clock; all state on its rising edge.
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port start, input, 1, requests one layer evaluation.
REQ-007 SHALL have port act_in, input, 4*IN_W, signed activations 0..3, with element k at bits [k*IN_W +: IN_W].
REQ-008 SHALL have port abort, input, 1, synchronous return to IDLE.
REQ-009 SHALL have port w_addr, output, clog2(NUM_NEURONS), weight-row address (the neuron index).
REQ-010 SHALL have port w_data, input, 20, four signed 5-bit weights for row w_addr, valid combinationally in the same cycle.
REQ-011 SHALL have port n_input_ready, output, 1, drives the neuron unit's input_ready.
REQ-012 SHALL have ports n_in0..n_in3, output, IN_W each, and n_w0..n_w3, output, 5 each, which drive the neuron unit's operand pairs.
REQ-013 SHALL have port n_result_ready, input, 1, and port n_result, input, OUT_W, both taken from the neuron unit.
REQ-014 SHALL have port out_valid, output, 1, and port out_ready, input, 1, forming the result stream handshake.
REQ-015 SHALL have ports out_data (output, OUT_W, signed result), out_idx (output, clog2(NUM_NEURONS), neuron index) and out_last (output, 1, high for the final neuron).
REQ-016 SHALL have ports busy (output, 1), done (output, 1, one-cycle pulse) and err (output, 1, sticky error flag).

Function
REQ-017 SHALL implement FSM states IDLE, ISSUE, WAIT, OUT.
REQ-018 IDLE: on start=1, SHALL latch act_in, set idx=0 and go to ISSUE; start SHALL be ignored in every other state.
REQ-019 ISSUE: SHALL drive n_input_ready=1, w_addr=idx, n_inK=latched act K and n_wK=w_data[5K+:5], then go to WAIT.
REQ-020 Outside ISSUE, n_input_ready and all n_in/n_w outputs SHALL be 0.
REQ-021 WAIT: SHALL capture n_result into result register res_q, then go to OUT.
REQ-022 WAIT: if n_result_ready=0, SHALL set err=1 and capture 0 instead of n_result.
REQ-023 OUT: SHALL assert out_valid=1 with out_data=res_q, out_idx=idx and out_last=(idx==NUM_NEURONS-1); all four outputs SHALL hold stable until out_ready=1.
REQ-024 OUT with out_ready=1 and not last: SHALL increment idx and go to ISSUE.
REQ-025 OUT with out_ready=1 and last: SHALL pulse done=1 for one cycle and go to IDLE.
REQ-026 The minimum interval per neuron SHALL be 3 cycles; a full layer SHALL take 3*NUM_NEURONS cycles from start to done, given out_ready held at 1.
REQ-027 busy SHALL be 1 in every state except IDLE.
REQ-028 abort=1 SHALL force IDLE with out_valid=0, without asserting done, and SHALL override every other transition, including the final out_ready.
REQ-029 start and abort in the same IDLE cycle SHALL leave the FSM in IDLE.
REQ-030 err SHALL clear only on reset or on an accepted start.

Reset
REQ-031 While rst_n=0, the FSM SHALL be in IDLE and idx, res_q, latched activations, and all outputs (out_valid, done, err, busy, n_input_ready, w_addr, out_data, out_idx, out_last) SHALL be 0.
REQ-032 Reset asserted mid-layer SHALL discard the layer; no done pulse or out_valid SHALL follow the release of reset.

Configuration
REQ-033 With macro NEURON_RELU_EN defined, res_q SHALL capture max(n_result, 0); without it, res_q SHALL capture n_result unmodified (two's complement).

Verification
REQ-034 Scenario: act=(1,2,3,4), row0 w=(1,1,1,1), out_ready=1 -> out_data=10, out_idx=0 on cycle 3 after start.
REQ-035 Scenario: row1 w=(-1,-1,-1,-1), same act -> out_data=-10 (0xFF6) without NEURON_RELU_EN, and 0 with it.
REQ-036 Scenario: NUM_NEURONS=8, out_ready=1 throughout -> 8 beats with idx 0..7, out_last only on idx 7, done at cycle 24, busy low afterwards.
REQ-037 Scenario: out_ready=0 for 5 cycles in OUT -> out_valid/out_data/out_idx stable, no n_input_ready pulse during the stall.
REQ-038 Scenario: neuron model that never raises n_result_ready -> err=1, out_data=0, sequencing continues; next accepted start clears err.
REQ-039 Scenario: abort at idx 3, or rst_n low at idx 3 -> IDLE next cycle, no done pulse; a new start restarts at idx 0.

Source files
------------

// File: rtl/neuron_layer_seq.sv
// neuron_layer_seq: sequences NUM_NEURONS evaluations through one shared
// four-input neuron unit and streams the results out with a valid/ready
// handshake.
// Optional feature: define NEURON_RELU_EN to clamp captured results at zero.
module neuron_layer_seq #(
    parameter int IN_W        = 5,
    parameter int OUT_W       = 12,
    parameter int NUM_NEURONS = 8
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 start,
    input  logic [4*IN_W-1:0]                    act_in,
    input  logic                                 abort,
    output logic [$clog2(NUM_NEURONS)-1:0]       w_addr,
    input  logic [19:0]                          w_data,
    output logic                                 n_input_ready,
    output logic [IN_W-1:0]                      n_in0,
    output logic [IN_W-1:0]                      n_in1,
    output logic [IN_W-1:0]                      n_in2,
    output logic [IN_W-1:0]                      n_in3,
    output logic [4:0]                           n_w0,
    output logic [4:0]                           n_w1,
    output logic [4:0]                           n_w2,
    output logic [4:0]                           n_w3,
    input  logic                                 n_result_ready,
    input  logic [OUT_W-1:0]                     n_result,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [OUT_W-1:0]                     out_data,
    output logic [$clog2(NUM_NEURONS)-1:0]       out_idx,
    output logic                                 out_last,
    output logic                                 busy,
    output logic                                 done,
    output logic                                 err
);

    localparam int unsigned IDX_W = $clog2(NUM_NEURONS);
    localparam int unsigned ACT_W = 4 * IN_W;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NEURONS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_OUT   = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [OUT_W-1:0]   res_q, res_d;
    logic [ACT_W-1:0]   act_q, act_d;
    logic [ACT_W-1:0]   n_in_q, n_in_d;
    logic               err_q, err_d;
    logic               done_q, done_d;
    logic               busy_q, busy_d;
    logic               valid_q, valid_d;
    logic               last_q, last_d;
    logic               nir_q, nir_d;
    logic [OUT_W-1:0]   captured;

    // Value stored from the neuron unit (optionally clamped at zero)
    always_comb begin
`ifdef NEURON_RELU_EN
        captured = n_result[OUT_W-1] ? '0 : n_result;
`else
        captured = n_result;
`endif
    end

    // Next-state and next-output logic; abort dominates every transition
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        res_d   = res_q;
        act_d   = act_q;
        err_d   = err_q;
        done_d  = 1'b0;
        if (abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        act_d   = act_in;
                        idx_d   = '0;
                        err_d   = 1'b0;
                        state_d = S_ISSUE;
                    end
                end
                S_ISSUE: state_d = S_WAIT;
                S_WAIT: begin
                    if (n_result_ready) begin
                        res_d = captured;
                    end else begin
                        res_d = '0;
                        err_d = 1'b1;
                    end
                    state_d = S_OUT;
                end
                S_OUT: begin
                    if (out_ready) begin
                        if (idx_q == LAST_IDX) begin
                            done_d  = 1'b1;
                            state_d = S_IDLE;
                        end else begin
                            idx_d   = idx_q + IDX_W'(1);
                            state_d = S_ISSUE;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
        busy_d  = (state_d != S_IDLE);
        valid_d = (state_d == S_OUT);
        last_d  = (state_d == S_OUT) && (idx_d == LAST_IDX);
        nir_d   = (state_d == S_ISSUE);
        n_in_d  = nir_d ? act_d : '0;
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            res_q   <= '0;
            act_q   <= '0;
            n_in_q  <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            nir_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            res_q   <= res_d;
            act_q   <= act_d;
            n_in_q  <= n_in_d;
            err_q   <= err_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            nir_q   <= nir_d;
        end
    end

    // Weights arrive combinationally for the row addressed during ISSUE
    assign n_w0 = nir_q ? w_data[4:0]   : 5'd0;
    assign n_w1 = nir_q ? w_data[9:5]   : 5'd0;
    assign n_w2 = nir_q ? w_data[14:10] : 5'd0;
    assign n_w3 = nir_q ? w_data[19:15] : 5'd0;

    assign n_in0 = n_in_q[0*IN_W +: IN_W];
    assign n_in1 = n_in_q[1*IN_W +: IN_W];
    assign n_in2 = n_in_q[2*IN_W +: IN_W];
    assign n_in3 = n_in_q[3*IN_W +: IN_W];

    assign n_input_ready = nir_q;
    assign w_addr        = idx_q;
    assign out_idx       = idx_q;
    assign out_data      = res_q;
    assign out_valid     = valid_q;
    assign out_last      = last_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign err           = err_q;

endmodule

// File: tb/tb_neuron_layer_seq.sv
// Bench for neuron_layer_seq: behavioural neuron unit and weight ROM, expected
// results computed from the layer's arithmetic definition.
module tb_neuron_layer_seq;

    localparam int IN_W  = 5;
    localparam int OUT_W = 12;
    localparam int NN    = 8;
    localparam int IDX_W = $clog2(NN);

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               start = 1'b0;
    logic [4*IN_W-1:0]  act_in = '0;
    logic               abort = 1'b0;
    logic [IDX_W-1:0]   w_addr;
    logic [19:0]        w_data;
    logic               n_input_ready;
    logic [IN_W-1:0]    n_in0, n_in1, n_in2, n_in3;
    logic [4:0]         n_w0, n_w1, n_w2, n_w3;
    logic               n_result_ready = 1'b0;
    logic [OUT_W-1:0]   n_result = '0;
    logic               out_valid;
    logic               out_ready = 1'b0;
    logic [OUT_W-1:0]   out_data;
    logic [IDX_W-1:0]   out_idx;
    logic               out_last;
    logic               busy, done, err;

    int tests_run = 0;
    int tests_failed = 0;

    int          act_v [4];
    int          wv    [NN][4];
    logic [19:0] wmem  [NN];
    bit          nrdy_kill = 1'b0;

    neuron_layer_seq #(.IN_W(IN_W), .OUT_W(OUT_W), .NUM_NEURONS(NN)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .act_in(act_in), .abort(abort),
        .w_addr(w_addr), .w_data(w_data), .n_input_ready(n_input_ready),
        .n_in0(n_in0), .n_in1(n_in1), .n_in2(n_in2), .n_in3(n_in3),
        .n_w0(n_w0), .n_w1(n_w1), .n_w2(n_w2), .n_w3(n_w3),
        .n_result_ready(n_result_ready), .n_result(n_result),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_idx(out_idx), .out_last(out_last),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    assign w_data = wmem[w_addr];

    // Behavioural neuron unit: answers one cycle after input_ready
    function automatic int dotn();
        return int'($signed(n_in0)) * int'($signed(n_w0)) + int'($signed(n_in1)) * int'($signed(n_w1))
             + int'($signed(n_in2)) * int'($signed(n_w2)) + int'($signed(n_in3)) * int'($signed(n_w3));
    endfunction

    always @(posedge clk) begin
        if (n_input_ready) begin
            n_result       <= OUT_W'(dotn());
            n_result_ready <= !nrdy_kill;
        end else begin
            n_result_ready <= 1'b0;
        end
    end

    // Expected layer output for neuron k from the stored activations and weights
    function automatic logic [OUT_W-1:0] exp_result(input int k);
        int s;
        s = 0;
        for (int i = 0; i < 4; i++) s += act_v[i] * wv[k][i];
`ifdef NEURON_RELU_EN
        if (s < 0) s = 0;
`endif
        return OUT_W'(s);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_row(input int k, input int a, input int b, input int c, input int d);
        logic [19:0] t;
        wv[k][0] = a; wv[k][1] = b; wv[k][2] = c; wv[k][3] = d;
        for (int i = 0; i < 4; i++) t[i*5 +: 5] = 5'(wv[k][i]);
        wmem[k] = t;
    endtask

    task automatic set_act(input int a, input int b, input int c, input int d);
        act_v[0] = a; act_v[1] = b; act_v[2] = c; act_v[3] = d;
        for (int i = 0; i < 4; i++) act_in[i*IN_W +: IN_W] = IN_W'(act_v[i]);
    endtask

    task automatic rand_weights();
        for (int k = 0; k < NN; k++)
            set_row(k, int'($urandom_range(31)) - 16, int'($urandom_range(31)) - 16,
                       int'($urandom_range(31)) - 16, int'($urandom_range(31)) - 16);
    endtask

    task automatic rand_act();
        set_act(int'($urandom_range(31)) - 16, int'($urandom_range(31)) - 16,
                int'($urandom_range(31)) - 16, int'($urandom_range(31)) - 16);
    endtask

    // Full layer with optional random backpressure; checks every beat and done
    task automatic run_layer(input int stall_pct, input bit hold_start, input bit no_rdy);
        int  cyc, k;
        bit  seen_done;
        logic [OUT_W-1:0] e;
        nrdy_kill = no_rdy;
        rand_act();
        start = 1'b1;
        tick();
        start = hold_start;
        tests_run++;
        if (busy !== 1'b1 || n_input_ready !== 1'b1 || out_valid !== 1'b0 || err !== 1'b0) begin
            tests_failed++;
            $display("FAIL start_accept: busy=%b nir=%b valid=%b err=%b want 1 1 0 0",
                     busy, n_input_ready, out_valid, err);
        end
        cyc = 0; k = 0; seen_done = 1'b0;
        while (!seen_done && cyc < 3000) begin
            out_ready = ($urandom_range(99) >= stall_pct);
            if (out_valid) begin
                e = no_rdy ? '0 : exp_result(k);
                tests_run++;
                if (out_data !== e || out_idx !== IDX_W'(k) || out_last !== (k == NN - 1)
                    || n_input_ready !== 1'b0 || busy !== 1'b1) begin
                    tests_failed++;
                    $display("FAIL beat k=%0d: data=%h idx=%0d last=%b nir=%b busy=%b want data=%h idx=%0d last=%b",
                             k, out_data, out_idx, out_last, n_input_ready, busy, e, k, (k == NN - 1));
                end
                if (stall_pct == 0) begin
                    tests_run++;
                    if (cyc != 3 * k + 2) begin
                        tests_failed++;
                        $display("FAIL beat_timing k=%0d: cycle=%0d want %0d", k, cyc, 3 * k + 2);
                    end
                end
                if (out_ready) begin
                    k++;
                    if (k == NN) start = 1'b0;
                end
            end
            tick();
            cyc++;
            if (done === 1'b1) seen_done = 1'b1;
        end
        out_ready = 1'b0;
        start = 1'b0;
        tests_run++;
        if (!seen_done || k != NN || busy !== 1'b0 || out_valid !== 1'b0 || err !== no_rdy
            || (stall_pct == 0 && cyc != 3 * NN)) begin
            tests_failed++;
            $display("FAIL layer_done: seen=%0d beats=%0d busy=%b valid=%b err=%b cycle=%0d want 1 %0d 0 0 %0d %0d",
                     seen_done, k, busy, out_valid, err, cyc, NN, no_rdy, 3 * NN);
        end
        tick();
        tests_run++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL done_pulse: done=%b busy=%b want 0 0", done, busy);
        end
        nrdy_kill = 1'b0;
    endtask

    // Start a layer and advance to the OUT cycle of neuron k (out_ready high)
    task automatic goto_out(input int k);
        rand_act();
        out_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3 * k + 2) tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick(); tick();
        tests_run++;
        if ({out_valid, done, err, busy, n_input_ready, out_last} !== 6'b0 || w_addr !== '0
            || out_data !== '0 || out_idx !== '0 || {n_in0, n_in1, n_in2, n_in3} !== '0
            || {n_w0, n_w1, n_w2, n_w3} !== '0) begin
            tests_failed++;
            $display("FAIL reset_state: valid=%b done=%b err=%b busy=%b nir=%b last=%b addr=%0d data=%h idx=%0d want all 0",
                     out_valid, done, err, busy, n_input_ready, out_last, w_addr, out_data, out_idx);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_scenario();
        logic [OUT_W-1:0] want1;
`ifdef NEURON_RELU_EN
        want1 = '0;
`else
        want1 = 12'hFF6;
`endif
        set_row(0, 1, 1, 1, 1);
        set_row(1, -1, -1, -1, -1);
        set_act(1, 2, 3, 4);
        out_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        tests_run++;
        if (n_in0 !== 5'd1 || n_in3 !== 5'd4 || n_w0 !== 5'd1 || w_addr !== '0) begin
            tests_failed++;
            $display("FAIL issue_operands: in0=%0d in3=%0d w0=%0d addr=%0d want 1 4 1 0",
                     n_in0, n_in3, n_w0, w_addr);
        end
        tick(); tick();
        tests_run++;
        if (out_valid !== 1'b1 || out_data !== 12'd10 || out_idx !== '0) begin
            tests_failed++;
            $display("FAIL scen_row0: valid=%b data=%h idx=%0d want 1 00a 0", out_valid, out_data, out_idx);
        end
        tick(); tick(); tick();
        tests_run++;
        if (out_valid !== 1'b1 || out_data !== want1 || out_idx !== IDX_W'(1)) begin
            tests_failed++;
            $display("FAIL scen_row1: valid=%b data=%h idx=%0d want 1 %h 1", out_valid, out_data, out_idx, want1);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        out_ready = 1'b0;
    endtask

    task automatic test_stall();
        logic [OUT_W-1:0] e;
        goto_out(0);
        out_ready = 1'b0;
        e = exp_result(0);
        repeat (5) begin
            tick();
            tests_run++;
            if (out_valid !== 1'b1 || out_data !== e || out_idx !== '0 || out_last !== 1'b0
                || n_input_ready !== 1'b0) begin
                tests_failed++;
                $display("FAIL stall_hold: valid=%b data=%h idx=%0d last=%b nir=%b want 1 %h 0 0 0",
                         out_valid, out_data, out_idx, out_last, n_input_ready, e);
            end
        end
        out_ready = 1'b1;
        tick();
        tests_run++;
        if (out_valid !== 1'b0 || n_input_ready !== 1'b1 || w_addr !== IDX_W'(1)) begin
            tests_failed++;
            $display("FAIL stall_release: valid=%b nir=%b addr=%0d want 0 1 1", out_valid, n_input_ready, w_addr);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        out_ready = 1'b0;
    endtask

    task automatic test_abort(input int at_idx);
        bit bad;
        goto_out(at_idx);
        tests_run++;
        if (out_valid !== 1'b1 || out_idx !== IDX_W'(at_idx)) begin
            tests_failed++;
            $display("FAIL abort_reach: valid=%b idx=%0d want 1 %0d", out_valid, out_idx, at_idx);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        out_ready = 1'b0;
        bad = (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || n_input_ready !== 1'b0);
        repeat (4) begin
            tick();
            if (out_valid !== 1'b0 || done !== 1'b0 || busy !== 1'b0) bad = 1'b1;
        end
        tests_run++;
        if (bad) begin
            tests_failed++;
            $display("FAIL abort_idx%0d: valid=%b busy=%b done=%b want 0 0 0", at_idx, out_valid, busy, done);
        end
        run_layer(0, 1'b0, 1'b0);
    endtask

    task automatic test_start_abort_idle();
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        tick();
        tests_run++;
        if (busy !== 1'b0 || n_input_ready !== 1'b0 || out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL start_abort_idle: busy=%b nir=%b valid=%b want 0 0 0", busy, n_input_ready, out_valid);
        end
    endtask

    task automatic test_reset_mid();
        bit bad;
        goto_out(3);
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || out_idx !== '0 || out_data !== '0) begin
            tests_failed++;
            $display("FAIL reset_mid: valid=%b busy=%b idx=%0d data=%h want 0 0 0 0", out_valid, busy, out_idx, out_data);
        end
        tick();
        rst_n = 1'b1;
        out_ready = 1'b0;
        bad = 1'b0;
        repeat (6) begin
            tick();
            if (out_valid !== 1'b0 || done !== 1'b0 || busy !== 1'b0) bad = 1'b1;
        end
        tests_run++;
        if (bad) begin
            tests_failed++;
            $display("FAIL reset_mid_quiet: valid=%b done=%b busy=%b want 0 0 0", out_valid, done, busy);
        end
        run_layer(0, 1'b0, 1'b0);
    endtask

    initial begin
        for (int k = 0; k < NN; k++) set_row(k, 0, 0, 0, 0);
        test_reset();
        test_scenario();
        rand_weights();
        run_layer(0, 1'b1, 1'b0);
        test_stall();
        for (int r = 0; r < 3; r++) run_layer(40, 1'b0, 1'b0);
        run_layer(0, 1'b0, 1'b1);
        run_layer(0, 1'b0, 1'b0);
        test_abort(3);
        test_abort(NN - 1);
        test_start_abort_idle();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
